// File: rtl/branch_predictor_btb.sv
// branch_predictor_btb: direct-mapped branch target buffer. Each entry has a
// saturating direction counter. Lookup is combinational from the current
// table state. Training comes through a single update port from the
// branch-resolution stage.
// Optional build macro: BPU_STATS_EN adds the update and mispredict
// statistics counters and their two output ports.
module branch_predictor_btb #(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 16,
    parameter int CTR_BITS = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            update_valid,
    input  logic [XLEN-1:0] update_pc,
    input  logic            update_taken,
    input  logic [XLEN-1:0] update_target,
    input  logic            update_is_jump,
    input  logic            update_mispredict,
    input  logic            flush_all
`ifdef BPU_STATS_EN
    ,
    output logic [31:0]     stat_updates,
    output logic [31:0]     stat_mispredicts
`endif
);

    localparam int IDX_BITS = $clog2(ENTRIES);
    localparam int TAG_BITS = XLEN - IDX_BITS - 2;

    // Counter encodings: 0 is strongly not-taken and all ones is strongly
    // taken. The MSB is the prediction.
    localparam logic [CTR_BITS-1:0] CTR_MAX     = '1;
    localparam logic [CTR_BITS-1:0] CTR_WEAK_T  = CTR_BITS'(1) << (CTR_BITS - 1);
    localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = CTR_WEAK_T - CTR_BITS'(1);

    // Table state. This uses flops rather than RAM, because reset clears
    // every entry asynchronously.
    logic                valid_reg  [ENTRIES];
    logic [TAG_BITS-1:0] tag_reg    [ENTRIES];
    logic [XLEN-1:0]     target_reg [ENTRIES];
    logic [CTR_BITS-1:0] ctr_reg    [ENTRIES];

    // Lookup side
    logic [IDX_BITS-1:0] lookup_idx;
    logic [TAG_BITS-1:0] lookup_tag;

    // Update side
    logic [IDX_BITS-1:0] update_idx;
    logic [TAG_BITS-1:0] update_tag;
    logic                upd_hit;
    logic                upd_alloc;
    logic                upd_wr;
    logic                upd_target_we;
    logic [CTR_BITS-1:0] ctr_cur;
    logic [CTR_BITS-1:0] ctr_next;

    // Bits that play no part in indexing. When stats are disabled, the
    // mispredict flag also goes unused.
    logic unused_ok;
    assign unused_ok = ^{lookup_pc[1:0], update_pc[1:0], update_mispredict};

    assign lookup_idx = lookup_pc[IDX_BITS+1:2];
    assign lookup_tag = lookup_pc[XLEN-1:IDX_BITS+2];
    assign update_idx = update_pc[IDX_BITS+1:2];
    assign update_tag = update_pc[XLEN-1:IDX_BITS+2];

    // Zero-latency prediction from the current table state. There is no
    // bypass from a same-cycle update.
    always_comb begin
        pred_hit    = valid_reg[lookup_idx] && (tag_reg[lookup_idx] == lookup_tag);
        pred_taken  = pred_hit && ctr_reg[lookup_idx][CTR_BITS-1];
        pred_target = pred_taken ? target_reg[lookup_idx] : (lookup_pc + XLEN'(4));
    end

    // Training decision: hit/allocate qualification and the next counter value
    always_comb begin
        ctr_cur       = ctr_reg[update_idx];
        upd_hit       = valid_reg[update_idx] && (tag_reg[update_idx] == update_tag);
        upd_alloc     = !upd_hit && (update_taken || update_is_jump);
        // A flush in the same cycle wins: nothing is written.
        upd_wr        = update_valid && !flush_all && (upd_hit || upd_alloc);
        upd_target_we = update_taken || update_is_jump;
        ctr_next      = ctr_cur;
        if (!upd_hit) begin
            ctr_next = update_is_jump ? CTR_MAX : CTR_WEAK_T;
        end else if (update_is_jump) begin
            ctr_next = CTR_MAX;
        end else if (update_taken) begin
            ctr_next = (ctr_cur == CTR_MAX) ? CTR_MAX : ctr_cur + CTR_BITS'(1);
        end else begin
            ctr_next = (ctr_cur == '0) ? '0 : ctr_cur - CTR_BITS'(1);
        end
    end

    // One register slice per entry. Only the indexed entry takes the update.
    // Flush clears valid bits only.
    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            // Per-entry valid/tag/target/counter state
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_reg[gi]  <= 1'b0;
                    tag_reg[gi]    <= '0;
                    target_reg[gi] <= '0;
                    ctr_reg[gi]    <= CTR_WEAK_NT;
                end else if (flush_all) begin
                    valid_reg[gi]  <= 1'b0;
                end else if (upd_wr && (update_idx == IDX_BITS'(gi))) begin
                    valid_reg[gi]  <= 1'b1;
                    tag_reg[gi]    <= update_tag;
                    ctr_reg[gi]    <= ctr_next;
                    if (upd_target_we) begin
                        target_reg[gi] <= update_target;
                    end
                end
            end
        end
    endgenerate

`ifdef BPU_STATS_EN
    logic [31:0] stat_updates_reg;
    logic [31:0] stat_mispredicts_reg;

    // Saturating training statistics. Only reset clears them; flush does not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_updates_reg     <= '0;
            stat_mispredicts_reg <= '0;
        end else begin
            if (update_valid && (stat_updates_reg != 32'hFFFF_FFFF)) begin
                stat_updates_reg <= stat_updates_reg + 32'd1;
            end
            if (update_valid && update_mispredict &&
                (stat_mispredicts_reg != 32'hFFFF_FFFF)) begin
                stat_mispredicts_reg <= stat_mispredicts_reg + 32'd1;
            end
        end
    end

    assign stat_updates     = stat_updates_reg;
    assign stat_mispredicts = stat_mispredicts_reg;
`endif

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed testbench for branch_predictor_btb (ENTRIES=16, CTR_BITS=2, XLEN=32).
// When BPU_STATS_EN is defined, it also covers the statistics counters.
module tb_branch_predictor_btb;

    logic        clk;
    logic        rst;
    logic [31:0] lookup_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic        update_is_jump;
    logic        update_mispredict;
    logic        flush_all;
`ifdef BPU_STATS_EN
    logic [31:0] stat_updates;
    logic [31:0] stat_mispredicts;
`endif

    int checks;
    int passed;

    branch_predictor_btb #(
        .XLEN     (32),
        .ENTRIES  (16),
        .CTR_BITS (2)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .lookup_pc         (lookup_pc),
        .pred_hit          (pred_hit),
        .pred_taken        (pred_taken),
        .pred_target       (pred_target),
        .update_valid      (update_valid),
        .update_pc         (update_pc),
        .update_taken      (update_taken),
        .update_target     (update_target),
        .update_is_jump    (update_is_jump),
        .update_mispredict (update_mispredict),
        .flush_all         (flush_all)
`ifdef BPU_STATS_EN
        ,
        .stat_updates      (stat_updates),
        .stat_mispredicts  (stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic ehit,
                        input logic etaken, input logic [31:0] etarget);
        lookup_pc = pc;
        #1;
        chk({tag, ".hit"}, {31'd0, pred_hit}, {31'd0, ehit});
        chk({tag, ".taken"}, {31'd0, pred_taken}, {31'd0, etaken});
        chk({tag, ".target"}, pred_target, etarget);
    endtask

    // Drive one training transaction, take the clock edge, then drop it.
    task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                       input logic jump, input logic misp, input logic flush);
        update_valid      = 1'b1;
        update_pc         = pc;
        update_taken      = taken;
        update_target     = tgt;
        update_is_jump    = jump;
        update_mispredict = misp;
        flush_all         = flush;
        @(posedge clk);
        #1;
        $display("update pc=%h taken=%0b jump=%0b target=%h misp=%0b flush=%0b",
                 pc, taken, jump, tgt, misp, flush);
        update_valid      = 1'b0;
        update_mispredict = 1'b0;
        flush_all         = 1'b0;
    endtask

    initial begin
        checks            = 0;
        passed            = 0;
        rst               = 1'b1;
        lookup_pc         = 32'h100;
        update_valid      = 1'b0;
        update_pc         = '0;
        update_taken      = 1'b0;
        update_target     = '0;
        update_is_jump    = 1'b0;
        update_mispredict = 1'b0;
        flush_all         = 1'b0;

        // Outputs during reset
        look("rst_100", 32'h100, 1'b0, 1'b0, 32'h104);
        look("rst_wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        look("post_rst_100", 32'h100, 1'b0, 1'b0, 32'h104);
`ifdef BPU_STATS_EN
        chk("stat_upd_rst", stat_updates, 32'd0);
        chk("stat_mis_rst", stat_mispredicts, 32'd0);
`endif

        // Allocate: the same-cycle lookup still sees the pre-update state.
        update_valid  = 1'b1;
        update_pc     = 32'h100;
        update_taken  = 1'b1;
        update_target = 32'h40;
        look("same_cycle", 32'h100, 1'b0, 1'b0, 32'h104);
        upd(32'h100, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
        look("alloc_100", 32'h100, 1'b1, 1'b1, 32'h40);

        // Saturate up to 3, then walk down.
        upd(32'h100, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
        upd(32'h100, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
        look("ctr3", 32'h100, 1'b1, 1'b1, 32'h40);
        upd(32'h100, 1'b0, 32'h999, 1'b0, 1'b0, 1'b0);
        look("ctr2", 32'h100, 1'b1, 1'b1, 32'h40);
        upd(32'h100, 1'b0, 32'h999, 1'b0, 1'b0, 1'b0);
        look("ctr1", 32'h100, 1'b1, 1'b0, 32'h104);
        upd(32'h100, 1'b0, 32'h999, 1'b0, 1'b0, 1'b0);
        look("ctr0", 32'h100, 1'b1, 1'b0, 32'h104);
        upd(32'h100, 1'b0, 32'h999, 1'b0, 1'b0, 1'b0);
        look("ctr0_sat", 32'h100, 1'b1, 1'b0, 32'h104);
        // From 0, one taken update gives 1 (still not-taken) and the next gives 2.
        upd(32'h100, 1'b1, 32'h44, 1'b0, 1'b0, 1'b0);
        look("ctr0_to1", 32'h100, 1'b1, 1'b0, 32'h104);
        upd(32'h100, 1'b1, 32'h44, 1'b0, 1'b0, 1'b0);
        look("ctr1_to2", 32'h100, 1'b1, 1'b1, 32'h44);

        // Alias eviction at index 0
        look("alias_miss", 32'h140, 1'b0, 1'b0, 32'h144);
        upd(32'h140, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
        look("alias_140", 32'h140, 1'b1, 1'b1, 32'h200);
        look("evicted_100", 32'h100, 1'b0, 1'b0, 32'h104);
        upd(32'h180, 1'b0, 32'h300, 1'b0, 1'b0, 1'b0);
        look("nt_miss_180", 32'h180, 1'b0, 1'b0, 32'h184);
        look("kept_140", 32'h140, 1'b1, 1'b1, 32'h200);

        // Jump allocates strongly taken, even though update_taken is low.
        upd(32'h20, 1'b0, 32'h800, 1'b1, 1'b0, 1'b0);
        look("jump_20", 32'h20, 1'b1, 1'b1, 32'h800);
        upd(32'h20, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        look("jump_ctr3", 32'h20, 1'b1, 1'b1, 32'h800);

        // Flush overrides a simultaneous allocation.
        upd(32'h24, 1'b1, 32'h900, 1'b0, 1'b1, 1'b1);
        look("flush_20", 32'h20, 1'b0, 1'b0, 32'h24);
        look("flush_24", 32'h24, 1'b0, 1'b0, 32'h28);
        look("flush_140", 32'h140, 1'b0, 1'b0, 32'h144);

`ifdef BPU_STATS_EN
        // Statistics: 3 fresh updates after a reset, one of them mispredicted.
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        chk("stat_upd_clr", stat_updates, 32'd0);
        upd(32'h30, 1'b1, 32'h60, 1'b0, 1'b0, 1'b0);
        upd(32'h30, 1'b1, 32'h60, 1'b0, 1'b1, 1'b0);
        upd(32'h34, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("stat_upd_3", stat_updates, 32'd3);
        chk("stat_mis_1", stat_mispredicts, 32'd1);
        flush_all = 1'b1;
        @(posedge clk);
        #1;
        flush_all = 1'b0;
        chk("stat_upd_flush", stat_updates, 32'd3);
        chk("stat_mis_flush", stat_mispredicts, 32'd1);
`endif

        // Asynchronous reset mid-cycle clears the table without a clock edge.
        upd(32'h100, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
        look("pre_async", 32'h100, 1'b1, 1'b1, 32'h40);
        rst = 1'b1;
        #1;
        look("async_rst", 32'h100, 1'b0, 1'b0, 32'h104);
`ifdef BPU_STATS_EN
        chk("stat_upd_async", stat_updates, 32'd0);
        chk("stat_mis_async", stat_mispredicts, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        look("after_rst", 32'h100, 1'b0, 1'b0, 32'h104);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
